// File: rtl/mmu_pkg.sv
// Shared constants and types for the mmu_xlate address translation slice.
// Exception codes, request encodings and the registered result bundle.
package mmu_pkg;

  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_4M = 6'd21;

  typedef enum logic [1:0] {
    REQ_FETCH = 2'b00,
    REQ_LOAD  = 2'b01,
    REQ_STORE = 2'b10,
    REQ_RSVD  = 2'b11
  } req_type_e;

  typedef struct packed {
    logic        exc;
    logic [5:0]  ecode;
    logic [31:0] pa;
    logic [1:0]  mat;
  } xlate_res_t;

endpackage

// File: rtl/mmu_xlate_if.sv
// TLB search port bundle between mmu_xlate (master) and the TLB (slave).
// The search key flows out; the hit record flows back combinationally.
interface mmu_xlate_if #(
  parameter int TLBNUM = 16
);
  localparam int IW = $clog2(TLBNUM);

  logic [18:0]   s_vppn;
  logic          s_va_bit12;
  logic [9:0]    s_asid;
  logic          s_found;
  logic [IW-1:0] s_index;
  logic [19:0]   s_ppn;
  logic [5:0]    s_ps;
  logic [1:0]    s_plv;
  logic [1:0]    s_mat;
  logic          s_d;
  logic          s_v;

  modport master (
    output s_vppn,
    output s_va_bit12,
    output s_asid,
    input  s_found,
    input  s_index,
    input  s_ppn,
    input  s_ps,
    input  s_plv,
    input  s_mat,
    input  s_d,
    input  s_v
  );

  modport slave (
    input  s_vppn,
    input  s_va_bit12,
    input  s_asid,
    output s_found,
    output s_index,
    output s_ppn,
    output s_ps,
    output s_plv,
    output s_mat,
    output s_d,
    output s_v
  );

endinterface

// File: rtl/mmu_dmw_match.sv
// Direct-map window hit test and PA/MAT formation for one DMW CSR.
// Purely combinational; instantiated once per window.
module mmu_dmw_match
  import mmu_pkg::*;
(
  input  logic [31:0] dmw,
  input  logic [1:0]  plv,
  input  logic [31:0] va,
  output logic        hit,
  output logic [31:0] pa,
  output logic [1:0]  mat
);

  logic plv_ok;
  logic unused_dmw;

  // PLV0 enables via bit0; every other level uses the PLV3 bit
  assign plv_ok = (plv == 2'd0) ? dmw[0] : dmw[3];
  assign hit    = plv_ok && (dmw[31:29] == va[31:29]);
  assign pa     = {dmw[27:25], va[28:0]};
  assign mat    = dmw[5:4];

  assign unused_dmw = ^{dmw[28], dmw[24:6], dmw[2:1]};

endmodule

// File: rtl/mmu_xlate.sv
// Single-stage VA->PA translation: DA, DMW0/1 and TLB paths, 1-cycle latency.
// Define MMU_XLATE_STATS_EN to add saturating request/fault counters.
module mmu_xlate
  import mmu_pkg::*;
#(
  parameter int TLBNUM = 16,
  localparam int IW = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_va,
  input  logic [1:0]    req_type,
  input  logic          csr_da,
  input  logic          csr_pg,
  input  logic [1:0]    csr_plv,
  input  logic [1:0]    csr_datm,
  input  logic [9:0]    csr_asid,
  input  logic [31:0]   csr_dmw0,
  input  logic [31:0]   csr_dmw1,
  mmu_xlate_if.master   tlb,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_pa,
  output logic [1:0]    rsp_mat,
  output logic          rsp_exc,
  output logic [5:0]    rsp_ecode,
  output logic [31:0]   rsp_badv,
  output logic [IW-1:0] rsp_tlb_index
`ifdef MMU_XLATE_STATS_EN
  ,
  output logic [31:0]   stat_req,
  output logic [31:0]   stat_tlbr,
  output logic [31:0]   stat_fault
`endif
);

  logic          is_fetch;
  logic          is_store;
  logic          da_mode;
  logic          dmw0_hit;
  logic          dmw1_hit;
  logic [31:0]   dmw0_pa;
  logic [31:0]   dmw1_pa;
  logic [1:0]    dmw0_mat;
  logic [1:0]    dmw1_mat;
  logic          sel_adef;
  logic          sel_da;
  logic          sel_dmw0;
  logic          sel_dmw1;
  logic          sel_tlb;
  logic          accept;
  xlate_res_t    tlb_res;
  xlate_res_t    res;

  logic          rsp_valid_q, rsp_valid_d;
  xlate_res_t    res_q, res_d;
  logic [31:0]   badv_q, badv_d;
  logic [IW-1:0] idx_q, idx_d;

  assign tlb.s_vppn     = req_va[31:13];
  assign tlb.s_va_bit12 = req_va[12];
  assign tlb.s_asid     = csr_asid;

  assign is_fetch = (req_type == REQ_FETCH);
  assign is_store = (req_type == REQ_STORE);
  assign da_mode  = csr_da || !csr_pg;

  mmu_dmw_match u_dmw0 (
    .dmw (csr_dmw0),
    .plv (csr_plv),
    .va  (req_va),
    .hit (dmw0_hit),
    .pa  (dmw0_pa),
    .mat (dmw0_mat)
  );

  mmu_dmw_match u_dmw1 (
    .dmw (csr_dmw1),
    .plv (csr_plv),
    .va  (req_va),
    .hit (dmw1_hit),
    .pa  (dmw1_pa),
    .mat (dmw1_mat)
  );

  // Priority chain flattened into one-hot selects
  assign sel_adef = is_fetch && (req_va[1:0] != 2'b00);
  assign sel_da   = !sel_adef && da_mode;
  assign sel_dmw0 = !sel_adef && !da_mode && dmw0_hit;
  assign sel_dmw1 = !sel_adef && !da_mode && !dmw0_hit
                    && dmw1_hit;
  assign sel_tlb  = !sel_adef && !da_mode && !dmw0_hit
                    && !dmw1_hit;

  always_comb begin
    tlb_res = '0;
    if (!tlb.s_found) begin
      tlb_res.exc   = 1'b1;
      tlb_res.ecode = ECODE_TLBR;
    end else if (!tlb.s_v) begin
      tlb_res.exc   = 1'b1;
      tlb_res.ecode = is_fetch ? ECODE_PIF :
                      is_store ? ECODE_PIS : ECODE_PIL;
    end else if (csr_plv > tlb.s_plv) begin
      tlb_res.exc   = 1'b1;
      tlb_res.ecode = ECODE_PPI;
    end else if (is_store && !tlb.s_d) begin
      tlb_res.exc   = 1'b1;
      tlb_res.ecode = ECODE_PME;
    end else begin
      tlb_res.pa  = (tlb.s_ps == PS_4K) ?
                    {tlb.s_ppn, req_va[11:0]} :
                    {tlb.s_ppn[19:9], req_va[20:0]};
      tlb_res.mat = tlb.s_mat;
    end
  end

  always_comb begin
    res = '0;
    unique case (1'b1)
      sel_adef: begin
        res.exc   = 1'b1;
        res.ecode = ECODE_ADEF;
      end
      sel_da: begin
        res.pa  = req_va;
        res.mat = csr_datm;
      end
      sel_dmw0: begin
        res.pa  = dmw0_pa;
        res.mat = dmw0_mat;
      end
      sel_dmw1: begin
        res.pa  = dmw1_pa;
        res.mat = dmw1_mat;
      end
      sel_tlb: res = tlb_res;
      default: res = '0;
    endcase
  end

  assign req_ready = !rsp_valid_q || rsp_ready;
  assign accept    = req_valid && req_ready && !flush;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    res_d       = res_q;
    badv_d      = badv_q;
    idx_d       = idx_q;
    if (flush) begin
      rsp_valid_d = 1'b0;
    end else if (accept) begin
      rsp_valid_d = 1'b1;
      res_d       = res;
      badv_d      = req_va;
      idx_d       = (sel_tlb && tlb.s_found) ?
                    tlb.s_index : '0;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_valid_q <= 1'b0;
      res_q       <= '0;
      badv_q      <= '0;
      idx_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      res_q       <= res_d;
      badv_q      <= badv_d;
      idx_q       <= idx_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_pa        = res_q.pa;
  assign rsp_mat       = res_q.mat;
  assign rsp_exc       = res_q.exc;
  assign rsp_ecode     = res_q.ecode;
  assign rsp_badv      = badv_q;
  assign rsp_tlb_index = idx_q;

`ifdef MMU_XLATE_STATS_EN
  logic [31:0] req_cnt_q, req_cnt_d;
  logic [31:0] tlbr_cnt_q, tlbr_cnt_d;
  logic [31:0] fault_cnt_q, fault_cnt_d;
  logic        is_tlbr;
  logic        is_fault;

  assign is_tlbr  = accept && sel_tlb && tlb_res.exc
                    && (tlb_res.ecode == ECODE_TLBR);
  assign is_fault = accept && sel_tlb && tlb_res.exc
                    && (tlb_res.ecode != ECODE_TLBR);

  always_comb begin
    req_cnt_d   = req_cnt_q;
    tlbr_cnt_d  = tlbr_cnt_q;
    fault_cnt_d = fault_cnt_q;
    if (accept && (req_cnt_q != '1))
      req_cnt_d = req_cnt_q + 32'd1;
    if (is_tlbr && (tlbr_cnt_q != '1))
      tlbr_cnt_d = tlbr_cnt_q + 32'd1;
    if (is_fault && (fault_cnt_q != '1))
      fault_cnt_d = fault_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_cnt_q   <= '0;
      tlbr_cnt_q  <= '0;
      fault_cnt_q <= '0;
    end else begin
      req_cnt_q   <= req_cnt_d;
      tlbr_cnt_q  <= tlbr_cnt_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign stat_req   = req_cnt_q;
  assign stat_tlbr  = tlbr_cnt_q;
  assign stat_fault = fault_cnt_q;
`endif

endmodule

// File: tb/tb_mmu_xlate.sv
// Self-checking bench for mmu_xlate: directed scenarios plus a randomized
// back-to-back run against a rule-level reference model.
module tb_mmu_xlate;
  import mmu_pkg::*;

  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          flush = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_va = '0;
  logic [1:0]    req_type = '0;
  logic          csr_da = 1'b0;
  logic          csr_pg = 1'b0;
  logic [1:0]    csr_plv = '0;
  logic [1:0]    csr_datm = '0;
  logic [9:0]    csr_asid = '0;
  logic [31:0]   csr_dmw0 = '0;
  logic [31:0]   csr_dmw1 = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_pa;
  logic [1:0]    rsp_mat;
  logic          rsp_exc;
  logic [5:0]    rsp_ecode;
  logic [31:0]   rsp_badv;
  logic [IW-1:0] rsp_tlb_index;
`ifdef MMU_XLATE_STATS_EN
  logic [31:0]   stat_req;
  logic [31:0]   stat_tlbr;
  logic [31:0]   stat_fault;
`endif

  mmu_xlate_if #(.TLBNUM(16)) tlb_if ();

  mmu_xlate #(.TLBNUM(16)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .flush         (flush),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_va        (req_va),
    .req_type      (req_type),
    .csr_da        (csr_da),
    .csr_pg        (csr_pg),
    .csr_plv       (csr_plv),
    .csr_datm      (csr_datm),
    .csr_asid      (csr_asid),
    .csr_dmw0      (csr_dmw0),
    .csr_dmw1      (csr_dmw1),
    .tlb           (tlb_if),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_pa        (rsp_pa),
    .rsp_mat       (rsp_mat),
    .rsp_exc       (rsp_exc),
    .rsp_ecode     (rsp_ecode),
    .rsp_badv      (rsp_badv),
    .rsp_tlb_index (rsp_tlb_index)
`ifdef MMU_XLATE_STATS_EN
    ,
    .stat_req      (stat_req),
    .stat_tlbr     (stat_tlbr),
    .stat_fault    (stat_fault)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        exc;
    logic [5:0]  ecode;
    logic [31:0] pa;
    logic [1:0]  mat;
  } exp_t;

  wire [41:0] got = {rsp_valid, rsp_exc, rsp_ecode, rsp_pa, rsp_mat};

  function automatic bit dmw_ok(input bit [31:0] d, input bit [31:0] va);
    bit allow;
    allow = (csr_plv == 0) ? d[0] : d[3];
    return allow && ((d >> 29) == (va >> 29));
  endfunction

  function automatic bit [31:0] dmw_pa(input bit [31:0] d,
                                       input bit [31:0] va);
    return (((d >> 25) & 32'h7) << 29) | (va & 32'h1FFF_FFFF);
  endfunction

  function automatic exp_t model();
    exp_t e;
    bit [31:0] va;
    bit [31:0] ppn;
    va  = req_va;
    ppn = 32'(tlb_if.s_ppn);
    e   = '0;
    if (req_type == 0 && (va % 4) != 0) begin
      e.exc = 1; e.ecode = 6'h08;
    end else if (csr_da || !csr_pg) begin
      e.pa = va; e.mat = csr_datm;
    end else if (dmw_ok(csr_dmw0, va)) begin
      e.pa = dmw_pa(csr_dmw0, va); e.mat = 2'((csr_dmw0 >> 4) & 3);
    end else if (dmw_ok(csr_dmw1, va)) begin
      e.pa = dmw_pa(csr_dmw1, va); e.mat = 2'((csr_dmw1 >> 4) & 3);
    end else if (!tlb_if.s_found) begin
      e.exc = 1; e.ecode = 6'h3F;
    end else if (!tlb_if.s_v) begin
      e.exc = 1;
      e.ecode = (req_type == 0) ? 6'h03 : (req_type == 2) ? 6'h02 : 6'h01;
    end else if (csr_plv > tlb_if.s_plv) begin
      e.exc = 1; e.ecode = 6'h07;
    end else if (req_type == 2 && !tlb_if.s_d) begin
      e.exc = 1; e.ecode = 6'h04;
    end else begin
      if (tlb_if.s_ps == 12)
        e.pa = (ppn << 12) | (va & 32'hFFF);
      else
        e.pa = ((ppn >> 9) << 21) | (va & 32'h1F_FFFF);
      e.mat = tlb_if.s_mat;
    end
    return e;
  endfunction

  task automatic set_tlb(input bit found, input bit [19:0] ppn,
                         input bit [5:0] ps, input bit [1:0] plv,
                         input bit d, input bit v);
    tlb_if.s_found = found;
    tlb_if.s_index = 4'd5;
    tlb_if.s_ppn   = ppn;
    tlb_if.s_ps    = ps;
    tlb_if.s_plv   = plv;
    tlb_if.s_mat   = 2'd2;
    tlb_if.s_d     = d;
    tlb_if.s_v     = v;
  endtask

  task automatic issue(input bit [31:0] va, input bit [1:0] typ);
    @(negedge clk);
    req_va = va; req_type = typ;
    req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    set_tlb(0, 0, 12, 0, 0, 0);
    resetn = 1'b0;
    #2;
    checks++;
    if ({rsp_valid, rsp_pa, rsp_mat, rsp_exc, rsp_ecode, rsp_badv,
         rsp_tlb_index} !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b pa=%h badv=%h want all 0",
               rsp_valid, rsp_pa, rsp_badv);
    end
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_da();
    csr_da = 1; csr_datm = 2'b01;
    req_va = 32'h1C00_0100;
    #1;
    checks++;
    if (tlb_if.s_vppn !== req_va[31:13] || tlb_if.s_va_bit12 !== req_va[12])
    begin
      errors++;
      $display("FAIL search_key: got %h want %h", tlb_if.s_vppn,
               req_va[31:13]);
    end
    issue(32'h1C00_0100, 2'b01);
    checks++;
    if (got !== {1'b1, 1'b0, 6'h00, 32'h1C00_0100, 2'b01}) begin
      errors++;
      $display("FAIL da_load: got %h want pa=1c000100 mat=1", got);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: got rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_dmw();
    csr_da = 0; csr_pg = 1; csr_plv = 0;
    csr_dmw0 = 32'hA000_0011; csr_dmw1 = 0;
    set_tlb(1, 20'h12345, 12, 3, 1, 1);
    issue(32'hA000_1234, 2'b01);
    checks++;
    if (got !== {1'b1, 1'b0, 6'h00, 32'h0000_1234, 2'b01}) begin
      errors++;
      $display("FAIL dmw0_hit: got %h want pa=00001234 mat=1", got);
    end
    csr_plv = 3;
    issue(32'hA000_1234, 2'b01);
    checks++;
    if (got !== {1'b1, 1'b0, 6'h00, 32'h1234_5234, 2'b10}
        || rsp_tlb_index !== 4'd5) begin
      errors++;
      $display("FAIL dmw0_plv3_tlb: got %h idx=%0d want pa=12345234 idx=5",
               got, rsp_tlb_index);
    end
  endtask

  task automatic test_tlb_store();
    csr_plv = 0; csr_dmw0 = 0; csr_dmw1 = 0;
    set_tlb(1, 20'h12345, 12, 0, 0, 1);
    issue(32'h0040_0ABC, 2'b10);
    checks++;
    if (got !== {1'b1, 1'b1, 6'h04, 32'h0, 2'b00}
        || rsp_badv !== 32'h0040_0ABC) begin
      errors++;
      $display("FAIL store_pme: got %h badv=%h want ecode=04", got, rsp_badv);
    end
    tlb_if.s_d = 1;
    issue(32'h0040_0ABC, 2'b10);
    checks++;
    if (got !== {1'b1, 1'b0, 6'h00, 32'h1234_5ABC, 2'b10}) begin
      errors++;
      $display("FAIL store_ok: got %h want pa=12345abc", got);
    end
  endtask

  task automatic test_tlb_faults();
    set_tlb(0, 20'h12345, 12, 0, 1, 1);
    issue(32'h0040_0AB0, 2'b01);
    checks++;
    if (got !== {1'b1, 1'b1, 6'h3F, 32'h0, 2'b00}
        || rsp_badv !== 32'h0040_0AB0) begin
      errors++;
      $display("FAIL tlbr: got %h badv=%h want ecode=3f", got, rsp_badv);
    end
    set_tlb(1, 20'h12345, 12, 0, 1, 0);
    issue(32'h0040_0AB0, 2'b00);
    checks++;
    if (got !== {1'b1, 1'b1, 6'h03, 32'h0, 2'b00}) begin
      errors++;
      $display("FAIL pif: got %h want ecode=03", got);
    end
    set_tlb(1, 20'h12345, 12, 0, 1, 1);
    csr_plv = 3;
    issue(32'h0040_0AB0, 2'b01);
    checks++;
    if (got !== {1'b1, 1'b1, 6'h07, 32'h0, 2'b00}) begin
      errors++;
      $display("FAIL ppi: got %h want ecode=07", got);
    end
    csr_plv = 0; csr_da = 1;
    issue(32'h0040_0AB2, 2'b00);
    checks++;
    if (got !== {1'b1, 1'b1, 6'h08, 32'h0, 2'b00}
        || rsp_badv !== 32'h0040_0AB2) begin
      errors++;
      $display("FAIL adef: got %h badv=%h want ecode=08", got, rsp_badv);
    end
    csr_da = 0;
  endtask

  task automatic test_4m();
    set_tlb(1, 20'h00600, 21, 0, 1, 1);
    issue(32'h0012_3456, 2'b01);
    checks++;
    if (got !== {1'b1, 1'b0, 6'h00, 32'h0072_3456, 2'b10}) begin
      errors++;
      $display("FAIL page_4m: got %h want pa=00723456", got);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit [31:0] va;
    int bad;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      req_va   = $urandom;
      req_type = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) req_va[1:0] = 2'b00;
      csr_da   = ($urandom_range(0, 7) == 0);
      csr_pg   = ($urandom_range(0, 7) != 0);
      csr_plv  = 2'($urandom);
      csr_datm = 2'($urandom);
      csr_dmw0 = $urandom;
      csr_dmw1 = $urandom;
      if ($urandom_range(0, 2) == 0) csr_dmw0[31:29] = req_va[31:29];
      if ($urandom_range(0, 2) == 0) csr_dmw1[31:29] = req_va[31:29];
      tlb_if.s_found = ($urandom_range(0, 5) != 0);
      tlb_if.s_index = 4'($urandom);
      tlb_if.s_ppn   = 20'($urandom);
      tlb_if.s_ps    = $urandom_range(0, 1) ? 6'd12 : 6'd21;
      tlb_if.s_plv   = 2'($urandom);
      tlb_if.s_mat   = 2'($urandom);
      tlb_if.s_d     = 1'($urandom);
      tlb_if.s_v     = ($urandom_range(0, 5) != 0);
      req_valid = 1'b1; rsp_ready = 1'b1;
      e  = model();
      va = req_va;
      @(posedge clk); #1;
      checks++;
      if (got !== {1'b1, e} || rsp_badv !== va || req_ready !== 1'b1) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL b2b[%0d]: got %h badv=%h want %h badv=%h",
                   i, got, rsp_badv, {1'b1, e}, va);
      end
    end
    req_valid = 1'b0;
    csr_da = 1; csr_pg = 0;
  endtask

  task automatic test_handshake();
    issue(32'h0000_1000, 2'b01);
    @(negedge clk);
    req_va = 32'h0000_2000; req_valid = 1'b1; rsp_ready = 1'b0;
    csr_datm = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1
          || rsp_pa !== 32'h0000_1000) begin
        errors++;
        $display("FAIL stall[%0d]: ready=%b v=%b pa=%h want 0 1 00001000",
                 i, req_ready, rsp_valid, rsp_pa);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_release: got %b want 1", req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_pa !== 32'h0000_2000
        || rsp_mat !== 2'b11) begin
      errors++;
      $display("FAIL post_stall: v=%b pa=%h want 1 00002000", rsp_valid,
               rsp_pa);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    req_va = 32'h0000_3000; req_valid = 1'b1; rsp_ready = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got v=%b want 0", rsp_valid);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_accept_blocked: got v=%b want 0", rsp_valid);
    end
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_extra: got v=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    issue(32'h0000_4000, 2'b01);
    rsp_ready = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_pa !== 32'h0 || rsp_badv !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: v=%b pa=%h badv=%h want 0", rsp_valid,
               rsp_pa, rsp_badv);
    end
    @(negedge clk);
    resetn = 1'b1; rsp_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_da();
    test_dmw();
    test_tlb_store();
    test_tlb_faults();
    test_4m();
    test_back_to_back();
    test_handshake();
    test_flush();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
